input_port_ctrl: RTL and testbench
==================================

# input_port_ctrl

Per-input-port requester for the 5-port NoC router: buffers incoming flits, XY-routes each 5-flit packet from its head flit, and raises a request to exactly one output-port arbiter. It holds that request, streams the packet while granted, then releases it. This is the initiator side of the output arbiters' request/grant/valid protocol. Five instances sit in front of the crossbar: N, S, E, W, L.

## Interface
- FLIT_W, 32, flit width in bits
- COORD_W, 2, width of each X/Y coordinate; head flit dest x = flit[COORD_W-1:0], dest y = flit[2*COORD_W-1:COORD_W]
- X_ID, 1, this router's X coordinate
- Y_ID, 1, this router's Y coordinate
- DEPTH, 8, input FIFO depth in flits; power of 2, ≥ 2
- PKT_LEN, 5, flits per packet; fixed, head first

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; one clock; asynchronous assert, active-low
- in_valid_i  in  1  upstream flit present
- in_flit_i  in  FLIT_W  upstream flit
- in_ready_o  out  1  FIFO can accept; equals !full
- req_o  out  5  one-hot request to output arbiters; bit 0 N, 1 S, 2 E, 3 W, 4 L
- grant_i  in  5  bit k high when arbiter k's granted index equals this port
- out_ready_i  in  1  crossbar/downstream can take a flit this cycle
- valid_o  out  1  flit transferred this cycle; drives the arbiter's valid count
- flit_o  out  FLIT_W  FIFO head flit (show-ahead)

## Operation
- FIFO:
  - Push when in_valid_i && in_ready_o.
  - Pop when valid_o.
  - Push and pop can happen in the same cycle unless full; when full, in_ready_o=0 and there is no pass-through.
  - Pointers are log2(DEPTH) bits plus a wrap bit.
- Route decode, combinational from the FIFO head:
  - dx > X_ID → E
  - dx < X_ID → W
  - otherwise dy > Y_ID → N
  - otherwise dy < Y_ID → S
  - otherwise → L
- Unsigned compare; route is registered when leaving IDLE.
- FSM states: IDLE, REQ, SEND.
  - IDLE: req_o=0. If FIFO is non-empty, latch route, set req_o=onehot(route), go to REQ.
  - REQ: waiting for first grant. On transfer, cnt←1 and go to SEND.
  - SEND: each transfer increments cnt. On the transfer with cnt==PKT_LEN-1, clear cnt and req_o and go to IDLE.
- Transfer condition: valid_o = (state∈{REQ,SEND}) && grant_i[route] && !empty && out_ready_i.
- Grant bits other than grant_i[route] are ignored.
- Loss of grant or an empty FIFO mid-packet is a stall: req_o stays held, cnt is unchanged, valid_o=0.
- No preemption; the packet always completes.
- IDLE lasts at least one cycle between packets, so req_o is low for ≥1 cycle and the arbiter returns to its idle state before re-request.
- The flit at the FIFO head in IDLE is taken to be a head flit; framing relies on the fixed PKT_LEN.

## Timing
- Reset values: in_ready_o=1, req_o=0, valid_o=0, flit_o=0 (FIFO storage cleared), state=IDLE, cnt=0, pointers=0.
- Asserting rst_n mid-packet aborts immediately: req_o drops asynchronously and buffered flits are discarded.
- Head flit accepted at edge t → req_o high from edge t+1.
- Earliest head transfer is in cycle t+1 if grant_i is already high (combinational valid_o).
- Back-to-back transfers: 1 flit/cycle while granted, out_ready_i=1, and FIFO non-empty.
- Last flit transferred in cycle c → req_o low from edge c+1 → next packet's req_o earliest at edge c+2.
- in_ready_o and valid_o are combinational from registered state plus grant_i/out_ready_i; there is no combinational path from in_valid_i to in_ready_o.

## Test plan
1. Reset, then a single packet to (2,1) with X_ID=Y_ID=1 and grant_i=5'b00100 held, out_ready_i=1: req_o=5'b00100 one cycle after the head is accepted; 5 consecutive valid_o pulses carry the flits in order; req_o=0 after the 5th.
2. Routing sweep with dest (1,2), (1,0), (0,1), (1,1): req_o=5'b00001, 5'b00010, 5'b01000, 5'b10000 respectively; grant_i driven on a non-matching bit yields no valid_o.
3. Mid-packet stall: deassert grant_i for 3 cycles after flit 2, then toggle out_ready_i: valid_o=0 while stalled, req_o held, flit 3 resumes, still exactly 5 transfers.
4. FIFO full: hold grant low and push 9 flits: in_ready_o=0 after 8 accepted; 9th held upstream until the first pop, then accepted; no flit is lost or duplicated.
5. Back-to-back packets already buffered: req_o low for exactly 1 cycle between packets; the second packet's route is taken from its own head flit.
6. rst_n low during flit 3: req_o=0 and valid_o=0 immediately, in_ready_o=1, FIFO empty; a new packet afterwards routes correctly.

Source files
------------

// File: rtl/input_port_ctrl.sv
// input_port_ctrl: per-input-port requester of the 5-port NoC router.
// Buffers incoming flits in a show-ahead FIFO, XY-routes each fixed-length
// packet from its head flit, holds a one-hot request to a single output
// arbiter and streams the packet whenever that arbiter grants this port.
module input_port_ctrl #(
  parameter int FLIT_W  = 32,
  parameter int COORD_W = 2,
  parameter int X_ID    = 1,
  parameter int Y_ID    = 1,
  parameter int DEPTH   = 8,
  parameter int PKT_LEN = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [FLIT_W-1:0] in_flit_i,
  output logic              in_ready_o,
  output logic [4:0]        req_o,
  input  logic [4:0]        grant_i,
  input  logic              out_ready_i,
  output logic              valid_o,
  output logic [FLIT_W-1:0] flit_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PKT_LEN);
  localparam logic [COORD_W-1:0] X_C  = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] Y_C  = COORD_W'(Y_ID);
  localparam logic [CW-1:0]      LAST = CW'(PKT_LEN - 1);

  // One-hot output directions: bit 0 N, 1 S, 2 E, 3 W, 4 L.
  localparam logic [4:0] DIR_N = 5'b00001;
  localparam logic [4:0] DIR_S = 5'b00010;
  localparam logic [4:0] DIR_E = 5'b00100;
  localparam logic [4:0] DIR_W = 5'b01000;
  localparam logic [4:0] DIR_L = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  logic [FLIT_W-1:0]  mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  state_e             state_q, state_d;
  logic [4:0]         req_q, req_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               empty_s;
  logic               full_s;
  logic               push_s;
  logic [COORD_W-1:0] dx_s;
  logic [COORD_W-1:0] dy_s;
  logic [4:0]         route_oh_s;

  // FIFO status, handshakes and the show-ahead head flit.
  always_comb begin
    empty_s    = (wr_ptr_q == rd_ptr_q);
    full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    in_ready_o = !full_s;
    push_s     = in_valid_i && !full_s;
    flit_o     = mem_q[rd_ptr_q[AW-1:0]];
    // req_q is zero in IDLE, so the grant match alone already excludes IDLE;
    // the state term keeps the intent explicit.
    valid_o    = (state_q != ST_IDLE) && (|(grant_i & req_q)) &&
                 !empty_s && out_ready_i;
    wr_ptr_d   = push_s  ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d   = valid_o ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
  end

  // XY route decode of the flit at the FIFO head (X resolved before Y).
  always_comb begin
    dx_s = flit_o[COORD_W-1:0];
    dy_s = flit_o[2*COORD_W-1:COORD_W];
    if (dx_s > X_C) begin
      route_oh_s = DIR_E;
    end else if (dx_s < X_C) begin
      route_oh_s = DIR_W;
    end else if (dy_s > Y_C) begin
      route_oh_s = DIR_N;
    end else if (dy_s < Y_C) begin
      route_oh_s = DIR_S;
    end else begin
      route_oh_s = DIR_L;
    end
  end

  // Packet FSM next state: latch the route on leaving IDLE, count transfers,
  // drop the request after the last flit so IDLE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          req_d   = route_oh_s;
          state_d = ST_REQ;
        end else begin
          req_d   = 5'b00000;
        end
      end
      ST_REQ: begin
        if (valid_o) begin
          cnt_d   = CW'(1);
          state_d = ST_SEND;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SEND: begin
        if (valid_o && (cnt_q == LAST)) begin
          cnt_d   = {CW{1'b0}};
          req_d   = 5'b00000;
          state_d = ST_IDLE;
        end else if (valid_o) begin
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 5'b00000;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Packet FSM, registered request and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= 5'b00000;
      cnt_q    <= {CW{1'b0}};
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so flit_o reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {FLIT_W{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_flit_i;
    end
  end

  assign req_o = req_q;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Self-checking bench for input_port_ctrl: a routing table, hand-written
// corner sequences and randomized traffic, all compared cycle by cycle
// against a queue-based packet model.
module tb_input_port_ctrl;

  localparam int DEPTH   = 8;
  localparam int PKT_LEN = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_flit_i = 32'h0;
  logic        in_ready_o;
  logic [4:0]  req_o;
  logic [4:0]  grant_i = 5'b00000;
  logic        out_ready_i = 1'b1;
  logic        valid_o;
  logic [31:0] flit_o;

  input_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_flit_i(in_flit_i),
    .in_ready_o(in_ready_o), .req_o(req_o), .grant_i(grant_i),
    .out_ready_i(out_ready_i), .valid_o(valid_o), .flit_o(flit_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: buffered flits, packet-in-progress flag, route, count.
  logic [31:0] mq[$];
  logic [31:0] src[$];
  bit          m_busy = 1'b0;
  int          m_route = 0;
  int          m_sent = 0;
  bit          push_rand = 1'b0;
  bit          tog = 1'b0;
  int          vcount = 0;
  int          acc_count = 0;
  int          cyc = 0;
  int          first_v = -1;
  int          last_v = -1;
  bit          rec = 1'b0;
  logic [4:0]  req_hist[$];

  typedef struct {
    int         x;
    int         y;
    logic [4:0] pre_g;
    logic [4:0] exp_req;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Destination X first, then Y; direction index 0 N, 1 S, 2 E, 3 W, 4 L.
  function automatic int route_of(input logic [31:0] f);
    int dx;
    int dy;
    dx = int'(f[1:0]);
    dy = int'(f[3:2]);
    if (dx > 1) return 2;
    if (dx < 1) return 3;
    if (dy > 1) return 0;
    if (dy < 1) return 1;
    return 4;
  endfunction

  task automatic add_pkt(input int x, input int y);
    logic [31:0] h;
    h = $urandom();
    h[1:0] = x[1:0];
    h[3:2] = y[1:0];
    src.push_back(h);
    repeat (PKT_LEN - 1) src.push_back($urandom());
  endtask

  // One clock: drive, check outputs against the model, advance the model.
  task automatic cycle();
    logic [4:0] one;
    logic [4:0] exp_req;
    bit         exp_ready;
    bit         exp_valid;
    bit         acc;
    int         hroute;
    one = 5'b00001;
    in_valid_i = (src.size() > 0) && (!push_rand || ($urandom_range(0, 1) == 1));
    in_flit_i  = (src.size() > 0) ? src[0] : 32'h0;
    #1;
    exp_ready = (mq.size() < DEPTH);
    exp_req   = m_busy ? (one << m_route) : 5'b00000;
    exp_valid = m_busy && grant_i[m_route] && (mq.size() > 0) && out_ready_i;
    check("in_ready", {31'b0, in_ready_o}, {31'b0, exp_ready});
    check("req", {27'b0, req_o}, {27'b0, exp_req});
    check("valid", {31'b0, valid_o}, {31'b0, exp_valid});
    if (mq.size() > 0) check("flit", flit_o, mq[0]);
    if (rec) req_hist.push_back(req_o);
    if (valid_o) begin
      vcount++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (in_valid_i && in_ready_o) acc_count++;
    acc    = in_valid_i && exp_ready;
    hroute = (mq.size() > 0) ? route_of(mq[0]) : 0;
    @(posedge clk);
    if (!m_busy && mq.size() > 0) begin
      m_busy  = 1'b1;
      m_route = hroute;
      m_sent  = 0;
    end else if (exp_valid) begin
      void'(mq.pop_front());
      m_sent++;
      if (m_sent == PKT_LEN) m_busy = 1'b0;
    end
    if (acc) begin
      mq.push_back(in_flit_i);
      void'(src.pop_front());
    end
    cyc++;
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (src.size() == 0 && mq.size() == 0 && !m_busy) break;
      if (tog) out_ready_i = ~out_ready_i;
      cycle();
    end
    check(name, {27'b0, req_o}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {27'b0, req_o}, 32'h0);
    check({tag, "_valid"}, {31'b0, valid_o}, 32'h0);
    check({tag, "_ready"}, {31'b0, in_ready_o}, 32'h1);
    check({tag, "_flit"},  flit_o, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int gap;
    logic [4:0] r2;

    tbl[0] = '{2, 1, 5'b00100, 5'b00100};
    tbl[1] = '{1, 2, 5'b00010, 5'b00001};
    tbl[2] = '{1, 0, 5'b00001, 5'b00010};
    tbl[3] = '{0, 1, 5'b00100, 5'b01000};
    tbl[4] = '{1, 1, 5'b01111, 5'b10000};
    tbl[5] = '{3, 0, 5'b00010, 5'b00100};
    tbl[6] = '{0, 3, 5'b00001, 5'b01000};
    tbl[7] = '{1, 3, 5'b11110, 5'b00001};

    // Power-on reset.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single packet with grant held, then the routing sweep with wrong grants.
    for (int k = 0; k < 8; k++) begin
      vcount = 0;
      first_v = -1;
      add_pkt(tbl[k].x, tbl[k].y);
      grant_i = tbl[k].pre_g;
      out_ready_i = 1'b1;
      repeat (6) cycle();
      check($sformatf("route_%0d", k), {27'b0, req_o}, {27'b0, tbl[k].exp_req});
      grant_i = tbl[k].exp_req;
      drain($sformatf("route_%0d_done", k), 60);
      check($sformatf("route_%0d_len", k), vcount, PKT_LEN);
      if (k == 0) check("b2b_span", last_v - first_v, PKT_LEN - 1);
    end

    // Mid-packet stall: grant loss after flit 2, then out_ready toggling.
    vcount = 0;
    add_pkt(2, 1);
    grant_i = 5'b00100;
    for (int n = 0; n < 40 && vcount < 2; n++) cycle();
    check("stall_pre", vcount, 2);
    grant_i = 5'b00000;
    repeat (3) cycle();
    check("stall_cnt", vcount, 2);
    check("stall_req", {27'b0, req_o}, 32'h4);
    grant_i = 5'b00100;
    tog = 1'b1;
    drain("stall_done", 60);
    tog = 1'b0;
    out_ready_i = 1'b1;
    check("stall_len", vcount, PKT_LEN);

    // FIFO full: 10 flits offered with no grant, only 8 fit.
    vcount = 0;
    acc_count = 0;
    add_pkt(0, 1);
    add_pkt(1, 1);
    grant_i = 5'b00000;
    repeat (12) cycle();
    check("full_accepted", acc_count, DEPTH);
    check("full_ready", {31'b0, in_ready_o}, 32'h0);
    grant_i = 5'b11111;
    drain("full_done", 80);
    check("full_total_in", acc_count, 2 * PKT_LEN);
    check("full_total_out", vcount, 2 * PKT_LEN);

    // Back-to-back buffered packets: one-cycle request gap, new route.
    vcount = 0;
    grant_i = 5'b11111;
    out_ready_i = 1'b0;
    add_pkt(2, 1);
    add_pkt(1, 2);
    repeat (9) cycle();
    out_ready_i = 1'b1;
    req_hist.delete();
    rec = 1'b1;
    drain("b2b_done", 80);
    rec = 1'b0;
    i = 0;
    gap = 0;
    r2 = 5'b00000;
    while (i < req_hist.size() && req_hist[i] != 5'b00000) i++;
    while (i < req_hist.size() && req_hist[i] == 5'b00000) begin
      gap++;
      i++;
    end
    if (i < req_hist.size()) r2 = req_hist[i];
    check("b2b_first_req", {27'b0, (req_hist.size() > 0) ? req_hist[0] : 5'b00000}, 32'h4);
    check("b2b_gap", gap, 1);
    check("b2b_second_req", {27'b0, r2}, 32'h1);
    check("b2b_len", vcount, 2 * PKT_LEN);

    // Reset during flit 3, then a fresh packet.
    vcount = 0;
    add_pkt(2, 1);
    grant_i = 5'b00100;
    for (int n = 0; n < 40 && vcount < 2; n++) cycle();
    check("rst_pre", vcount, 2);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    mq.delete();
    src.delete();
    m_busy = 1'b0;
    m_sent = 0;
    in_valid_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) cycle();
    vcount = 0;
    add_pkt(1, 0);
    grant_i = 5'b00010;
    drain("rst_after_done", 60);
    check("rst_after_len", vcount, PKT_LEN);

    // Randomized traffic against the model.
    push_rand = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (src.size() < PKT_LEN) add_pkt($urandom_range(0, 3), $urandom_range(0, 3));
      grant_i = 5'($urandom_range(0, 31));
      out_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
    push_rand = 1'b0;
    grant_i = 5'b11111;
    out_ready_i = 1'b1;
    drain("rand_done", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
